issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler_pkg.sv | 27 ++
 rtl/proc_scoreboard.sv | 48 ++++
 rtl/issue_scheduler.sv | 121 ++++++++++++
 tb/tb_issue_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared processor definitions: instruction field layout, opcodes, type
// encodings and the issue scheduler FSM state encoding.
package issue_scheduler_pkg;

   localparam int IR_OP_HI    = 31;
   localparam int IR_OP_LO    = 26;
   localparam int IR_RD_HI    = 25;
   localparam int IR_RD_LO    = 21;
   localparam int IR_RS_HI    = 20;
   localparam int IR_RS_LO    = 16;
   localparam int IR_RT_HI    = 15;
   localparam int IR_RT_LO    = 11;
   localparam int IR_TYPE_BIT = 31;

   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic IR_TYPE_RR = 1'b0;
   localparam logic IR_TYPE_RM = 1'b1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_STALL  = 2'b01,
      ST_DRAIN  = 2'b10,
      ST_HALTED = 2'b11
   } sched_state_e;

endpackage

// File: rtl/proc_scoreboard.sv
// Register scoreboard: one busy bit per architectural register, set on issue,
// cleared on writeback, with a sticky error for writebacks to idle registers.
module proc_scoreboard
   import issue_scheduler_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        set_i,
   input  logic [4:0]  set_rd_i,
   input  logic        clr_i,
   input  logic [4:0]  clr_rd_i,
   output logic [31:0] busy_o,
   output logic        err_o
);

   logic [31:0] busy_q, busy_d;
   logic        err_q, err_d;

   // Clear is applied before set so a same-register set/clear leaves the bit set.
   always_comb begin
      busy_d = busy_q;
      err_d  = err_q;
      if (clr_i) begin
         if (busy_q[clr_rd_i]) begin
            busy_d[clr_rd_i] = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
      if (set_i) begin
         busy_d[set_rd_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy_o = busy_q;
   assign err_o  = err_q;

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue control: scoreboard hazard detection, stall/bubble generation
// and a RUN/STALL/DRAIN/HALTED sequencer for halt instructions.
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int WB_LAT = 3,
   parameter int CNT_W  = 16
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [31:0]      id_ir,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   output logic             issue,
   output logic             stall_if,
   output logic             bubble,
   output logic             halted,
   output logic [31:0]      busy_map,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             sb_err
);

   localparam int DRN_W = $clog2(WB_LAT + 1);
   localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(WB_LAT - 1);

   sched_state_e     state_q, state_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [5:0] op;
   logic [4:0] rd, rs, rt;
   logic       is_rr, is_halt, hazard;
   logic       issue_c, stall_c;
   logic       unused_ir;

   assign op        = id_ir[IR_OP_HI:IR_OP_LO];
   assign rd        = id_ir[IR_RD_HI:IR_RD_LO];
   assign rs        = id_ir[IR_RS_HI:IR_RS_LO];
   assign rt        = id_ir[IR_RT_HI:IR_RT_LO];
   assign is_rr     = (id_ir[IR_TYPE_BIT] == IR_TYPE_RR);
   assign is_halt   = (op == OP_HALT);
   assign unused_ir = ^id_ir[IR_RT_LO-1:0];

   // Registered busy_map only: a writeback releases its dependant one cycle later.
   assign hazard = !is_halt &&
                   (busy_map[rs] || (is_rr && busy_map[rt]) || busy_map[rd]);

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      issue_c = 1'b0;
      stall_c = 1'b1;
      case (state_q)
         ST_RUN, ST_STALL: begin
            issue_c = id_valid && !hazard && !is_halt;
            stall_c = id_valid && !issue_c;
            if (id_valid && is_halt) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LOAD;
            end else if (id_valid && hazard) begin
               state_d = ST_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (drain_q == '0) begin
               if (busy_map == '0) begin
                  state_d = ST_HALTED;
               end
            end else begin
               drain_d = drain_q - DRN_W'(1);
            end
         end
         default: begin
            state_d = ST_HALTED;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == ST_STALL && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         drain_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   proc_scoreboard u_sb (
      .clk_i    (clk1),
      .rst_ni   (rst_n),
      .set_i    (issue),
      .set_rd_i (rd),
      .clr_i    (wb_valid),
      .clr_rd_i (wb_rd),
      .busy_o   (busy_map),
      .err_o    (sb_err)
   );

   // Control outputs are forced quiet while reset is held.
   assign issue     = rst_n && issue_c;
   assign stall_if  = rst_n && stall_c;
   assign bubble    = !issue;
   assign halted    = (state_q == ST_HALTED);
   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed and randomized bench for issue_scheduler, with a behavioural model
// of the scoreboard/halt rules checked every cycle on two CNT_W variants.
module tb_issue_scheduler;
   import issue_scheduler_pkg::*;

   localparam int WB = 3;
   localparam logic [31:0] HALT_IR = 32'hFC00_0000;

   logic clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   logic        rst_n, id_valid, wb_valid;
   logic [31:0] id_ir;
   logic [4:0]  wb_rd;

   logic        issue_a, stall_if_a, bubble_a, halted_a, sb_err_a;
   logic [31:0] busy_a;
   logic [1:0]  state_a;
   logic [15:0] cnt_a;
   logic        issue_b, stall_if_b, bubble_b, halted_b, sb_err_b;
   logic [31:0] busy_b;
   logic [1:0]  state_b;
   logic [3:0]  cnt_b;

   issue_scheduler #(.WB_LAT(WB), .CNT_W(16)) dut (
      .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_ir(id_ir),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .issue(issue_a), .stall_if(stall_if_a),
      .bubble(bubble_a), .halted(halted_a), .busy_map(busy_a), .state(state_a),
      .stall_cnt(cnt_a), .sb_err(sb_err_a));

   issue_scheduler #(.WB_LAT(WB), .CNT_W(4)) dut4 (
      .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_ir(id_ir),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .issue(issue_b), .stall_if(stall_if_b),
      .bubble(bubble_b), .halted(halted_b), .busy_map(busy_b), .state(state_b),
      .stall_cnt(cnt_b), .sb_err(sb_err_b));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: mode 0=run 1=stall 2=drain 3=halted.
   bit m_busy[32];
   int m_mode, m_spent, m_stalls;
   bit m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_rr(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      return {IR_TYPE_RR, 5'b00001, rd, rs, rt, 11'h000};
   endfunction

   function automatic logic [31:0] mk_rm(input logic [4:0] rd, input logic [4:0] rs, input logic [15:0] imm);
      return {IR_TYPE_RM, 5'b00010, rd, rs, imm};
   endfunction

   function automatic logic [31:0] m_busy_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic bit m_hazard(input logic [31:0] ir);
      if (ir[31:26] == 6'b111111) return 1'b0;
      return m_busy[ir[20:16]] || (ir[31] == 1'b0 && m_busy[ir[15:11]]) || m_busy[ir[25:21]];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_mode = 0; m_spent = 0; m_stalls = 0; m_err = 1'b0;
   endtask

   // One clock cycle: check every output against the model, then advance it.
   task automatic step();
      bit is_halt, haz, e_issue, e_stall;
      logic [31:0] bv;
      int ca, cb;
      is_halt = (id_ir[31:26] == 6'b111111);
      haz     = m_hazard(id_ir);
      e_issue = id_valid && (m_mode < 2) && !haz && !is_halt;
      e_stall = (m_mode >= 2) || (id_valid && !e_issue);
      bv      = m_busy_vec();
      ca      = (m_stalls > 65535) ? 65535 : m_stalls;
      cb      = (m_stalls > 15) ? 15 : m_stalls;
      @(negedge clk1);
      check("issue",      32'(issue_a),    32'(e_issue));
      check("stall_if",   32'(stall_if_a), 32'(e_stall));
      check("bubble",     32'(bubble_a),   32'(!e_issue));
      check("halted",     32'(halted_a),   32'(m_mode == 3));
      check("busy_map",   busy_a,          bv);
      check("state",      32'(state_a),    32'(m_mode));
      check("stall_cnt",  32'(cnt_a),      32'(ca));
      check("sb_err",     32'(sb_err_a),   32'(m_err));
      check("issue4",     32'(issue_b),    32'(e_issue));
      check("stall_if4",  32'(stall_if_b), 32'(e_stall));
      check("bubble4",    32'(bubble_b),   32'(!e_issue));
      check("halted4",    32'(halted_b),   32'(m_mode == 3));
      check("busy_map4",  busy_b,          bv);
      check("state4",     32'(state_b),    32'(m_mode));
      check("stall_cnt4", 32'(cnt_b),      32'(cb));
      check("sb_err4",    32'(sb_err_b),   32'(m_err));
      @(posedge clk1);
      if (wb_valid) begin
         if (m_busy[wb_rd]) m_busy[wb_rd] = 1'b0;
         else m_err = 1'b1;
      end
      if (e_issue) m_busy[id_ir[25:21]] = 1'b1;
      if (m_mode == 1) m_stalls++;
      case (m_mode)
         0, 1: begin
            if (id_valid && is_halt) begin
               m_mode = 2; m_spent = 0;
            end else if (id_valid && haz) m_mode = 1;
            else m_mode = 0;
         end
         2: begin
            m_spent++;
            if (m_spent >= WB && bv == 32'h0) m_mode = 3;
         end
         default: m_mode = 3;
      endcase
      #1;
   endtask

   // Assert reset between edges, check its asynchronous effect, hold over an edge.
   task automatic do_reset();
      rst_n = 1'b1;
      #2;
      rst_n    = 1'b0;
      id_valid = 1'b1;
      id_ir    = mk_rr(5'd1, 5'd2, 5'd3);
      wb_valid = 1'b0;
      #1;
      check("rst_state",    32'(state_a),    32'h0);
      check("rst_busy",     busy_a,          32'h0);
      check("rst_halted",   32'(halted_a),   32'h0);
      check("rst_sb_err",   32'(sb_err_a),   32'h0);
      check("rst_cnt",      32'(cnt_a),      32'h0);
      check("rst_issue",    32'(issue_a),    32'h0);
      check("rst_stall_if", 32'(stall_if_a), 32'h0);
      check("rst_bubble",   32'(bubble_a),   32'h1);
      check("rst_state4",   32'(state_b),    32'h0);
      check("rst_busy4",    busy_b,          32'h0);
      check("rst_cnt4",     32'(cnt_b),      32'h0);
      model_clear();
      @(posedge clk1);
      #2;
      rst_n    = 1'b1;
      id_valid = 1'b0;
   endtask

   initial begin
      logic [4:0] cand[$];
      rst_n = 1'b0; id_valid = 1'b0; id_ir = '0; wb_valid = 1'b0; wb_rd = '0;
      model_clear();
      do_reset();

      // RAW stall on r3, released one cycle after writeback of r3
      id_valid = 1'b1; id_ir = mk_rr(5'd3, 5'd1, 5'd2);
      step();
      check("raw_busy3", busy_a, 32'h0000_0008);
      id_ir = mk_rr(5'd4, 5'd3, 5'd1);
      #1;
      check("raw_stalls", 32'({issue_a, stall_if_a, bubble_a}), 32'b011);
      step();
      check("raw_state_stall", 32'(state_a), 32'h1);
      step(); step();
      wb_valid = 1'b1; wb_rd = 5'd3;
      step();
      wb_valid = 1'b0;
      #1;
      check("raw_release", 32'(issue_a), 32'h1);
      step();
      check("raw_busy4", busy_a, 32'h0000_0010);

      // rm-type: rt field bits point at busy r4 but must be ignored
      id_ir = mk_rm(5'd5, 5'd5, 16'h2007);
      #1;
      check("rm_rt_ignored", 32'(issue_a), 32'h1);
      step();
      id_valid = 1'b0;

      // writeback to an idle register
      wb_valid = 1'b1; wb_rd = 5'd9;
      step();
      wb_valid = 1'b0;
      check("sberr_set", 32'(sb_err_a), 32'h1);
      check("sberr_busy", busy_a, 32'h0000_0030);
      step();
      check("sberr_sticky", 32'(sb_err_a), 32'h1);
      wb_valid = 1'b1; wb_rd = 5'd4; step();
      wb_rd = 5'd5; step();
      wb_valid = 1'b0;

      // halt with r3 pending: drain for WB cycles then halt
      do_reset();
      id_valid = 1'b1; id_ir = mk_rr(5'd3, 5'd1, 5'd2);
      step();
      id_ir = HALT_IR;
      #1;
      check("halt_no_issue", 32'(issue_a), 32'h0);
      step();
      id_valid = 1'b0;
      check("drain_enter", 32'(state_a), 32'h2);
      check("drain_busy", busy_a, 32'h0000_0008);
      wb_valid = 1'b1; wb_rd = 5'd3;
      step();
      wb_valid = 1'b0;
      step();
      check("drain_hold", 32'(state_a), 32'h2);
      step();
      check("halted_state", 32'(state_a), 32'h3);
      check("halted_flag", 32'(halted_a), 32'h1);
      id_valid = 1'b1; id_ir = mk_rr(5'd7, 5'd1, 5'd2);
      repeat (3) step();
      check("halted_no_issue", busy_a, 32'h0);

      // reset mid-DRAIN with r0..r7 pending
      do_reset();
      id_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         id_ir = mk_rr(5'(k), 5'd20, 5'd21);
         step();
      end
      id_ir = HALT_IR;
      step();
      id_valid = 1'b0;
      step();
      check("mid_drain_state", 32'(state_a), 32'h2);
      check("mid_drain_busy", busy_a, 32'h0000_00FF);
      do_reset();

      // long stall saturates the 4-bit counter
      id_valid = 1'b1; id_ir = mk_rr(5'd3, 5'd1, 5'd2);
      step();
      id_ir = mk_rr(5'd4, 5'd3, 5'd1);
      repeat (21) step();
      check("sat_cnt4", 32'(cnt_b), 32'd15);
      check("sat_cnt16", 32'(cnt_a), 32'd20);
      wb_valid = 1'b1; wb_rd = 5'd3;
      step();
      wb_valid = 1'b0;
      step();
      id_valid = 1'b0;

      // randomized traffic on a small register window
      do_reset();
      for (int i = 0; i < 480; i++) begin
         if (i % 80 == 79) do_reset();
         id_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) id_ir = HALT_IR;
         else if ($urandom_range(0, 1) == 0)
            id_ir = mk_rr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         else
            id_ir = mk_rm(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
         cand.delete();
         for (int r = 0; r < 32; r++) if (m_busy[r]) cand.push_back(5'(r));
         wb_valid = ($urandom_range(0, 2) != 0);
         if (cand.size() == 0 || $urandom_range(0, 9) == 0) wb_rd = 5'($urandom_range(0, 7));
         else wb_rd = cand[$urandom_range(0, cand.size() - 1)];
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
